// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: FSM states,
// access-length encodings and the memory-mapped IO boundary.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_IF_RD,
        MC_LS_RD,
        MC_LS_WR
    } mc_state_t;

    localparam logic [1:0]  LEN_B   = 2'd0;
    localparam logic [1:0]  LEN_H   = 2'd1;
    localparam logic [1:0]  LEN_W   = 2'd2;
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    // Encoding 3 is illegal and is served as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and load/store requests onto the
// byte-wide RAM bus and assembles/disassembles little-endian words.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,

    input  logic        if_to_mc_ready,
    input  logic [31:0] if_to_mc_PC,
    output logic        mc_valid,
    output logic        mc_to_if_ready,
    output logic [31:0] mc_to_if_inst,

    input  logic        lsb_to_mc_ready,
    input  logic        lsb_to_mc_wr,
    input  logic [31:0] lsb_to_mc_addr,
    input  logic [1:0]  lsb_to_mc_len,
    input  logic [31:0] lsb_to_mc_data,
    output logic        mc_to_lsb_ready,
    output logic [31:0] mc_to_lsb_data
);

    mc_state_t   r_state,    w_state;
    logic [31:0] r_base,     w_base;
    logic [2:0]  r_len,      w_len;
    logic [31:0] r_data,     w_data;
    logic [2:0]  r_cnt,      w_cnt;
    logic [31:0] r_buf,      w_buf;
    logic [31:0] r_mem_a,    w_mem_a;
    logic [7:0]  r_mem_dout, w_mem_dout;
    logic        r_mem_wr,   w_mem_wr;
    logic        r_mc_valid, w_mc_valid;
    logic        r_if_rdy,   w_if_rdy;
    logic [31:0] r_inst,     w_inst;
    logic        r_lsb_rdy,  w_lsb_rdy;
    logic [31:0] r_lsb_data, w_lsb_data;

    logic [1:0]  w_lane;
    logic [31:0] w_capture;
    logic [2:0]  w_wr_idx;
    logic [31:0] w_wr_addr;

    // Read data arrives one cycle behind its address, so the byte on mem_din
    // now belongs to lane r_cnt-1.
    assign w_lane = 2'(r_cnt - 3'd1);

    always_comb begin
        w_capture = r_buf;
        w_capture[{w_lane, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        w_state    = r_state;
        w_base     = r_base;
        w_len      = r_len;
        w_data     = r_data;
        w_cnt      = r_cnt;
        w_buf      = r_buf;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_mem_wr   = 1'b0;
        w_mc_valid = 1'b0;
        w_if_rdy   = 1'b0;
        w_inst     = r_inst;
        w_lsb_rdy  = 1'b0;
        w_lsb_data = r_lsb_data;
        w_wr_idx   = '0;
        w_wr_addr  = '0;

        case (r_state)
            MC_IDLE: begin
                if (!clr_in) begin
                    if (lsb_to_mc_ready) begin
                        w_base  = lsb_to_mc_addr;
                        w_len   = len_bytes(lsb_to_mc_len);
                        w_data  = lsb_to_mc_data;
                        w_cnt   = '0;
                        w_buf   = '0;
                        w_mem_a = lsb_to_mc_addr;
                        if (lsb_to_mc_wr) begin
                            w_state    = MC_LS_WR;
                            w_mem_dout = lsb_to_mc_data[7:0];
                            w_mem_wr   = !(io_buffer_full && is_io(lsb_to_mc_addr));
                        end else begin
                            w_state = MC_LS_RD;
                        end
                    end else if (if_to_mc_ready) begin
                        w_state    = MC_IF_RD;
                        w_base     = if_to_mc_PC;
                        w_len      = 3'd4;
                        w_cnt      = '0;
                        w_buf      = '0;
                        w_mem_a    = if_to_mc_PC;
                        w_mc_valid = 1'b1;
                    end
                end
            end

            MC_IF_RD, MC_LS_RD: begin
                if (clr_in) begin
                    w_state = MC_IDLE;
                end else begin
                    if (r_cnt != 3'd0) begin
                        w_buf = w_capture;
                    end
                    if (r_cnt == r_len) begin
                        w_state = MC_IDLE;
                        if (r_state == MC_IF_RD) begin
                            w_if_rdy = 1'b1;
                            w_inst   = w_capture;
                        end else begin
                            w_lsb_rdy  = 1'b1;
                            w_lsb_data = w_capture;
                        end
                    end else begin
                        if (r_cnt + 3'd1 < r_len) begin
                            w_mem_a = r_base + 32'(r_cnt + 3'd1);
                        end
                        w_cnt = r_cnt + 3'd1;
                    end
                end
            end

            MC_LS_WR: begin
                // r_cnt advances only once its byte has actually been issued.
                w_wr_idx = r_mem_wr ? r_cnt + 3'd1 : r_cnt;
                if (r_mem_wr && (w_wr_idx == r_len)) begin
                    w_state   = MC_IDLE;
                    w_lsb_rdy = 1'b1;
                end else begin
                    w_cnt      = w_wr_idx;
                    w_wr_addr  = r_base + 32'(w_wr_idx);
                    w_mem_a    = w_wr_addr;
                    w_mem_dout = r_data[{w_wr_idx[1:0], 3'b000} +: 8];
                    w_mem_wr   = !(io_buffer_full && is_io(w_wr_addr));
                end
            end

            default: w_state = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= MC_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_mc_valid <= 1'b0;
            r_if_rdy   <= 1'b0;
            r_inst     <= '0;
            r_lsb_rdy  <= 1'b0;
            r_lsb_data <= '0;
        end else if (rdy_in) begin
            r_state    <= w_state;
            r_base     <= w_base;
            r_len      <= w_len;
            r_data     <= w_data;
            r_cnt      <= w_cnt;
            r_buf      <= w_buf;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            r_mem_wr   <= w_mem_wr;
            r_mc_valid <= w_mc_valid;
            r_if_rdy   <= w_if_rdy;
            r_inst     <= w_inst;
            r_lsb_rdy  <= w_lsb_rdy;
            r_lsb_data <= w_lsb_data;
        end
    end

    assign mem_a           = r_mem_a;
    assign mem_dout        = r_mem_dout;
    assign mem_wr          = r_mem_wr;
    assign mc_valid        = r_mc_valid;
    assign mc_to_if_ready  = r_if_rdy;
    assign mc_to_if_inst   = r_inst;
    assign mc_to_lsb_ready = r_lsb_rdy;
    assign mc_to_lsb_data  = r_lsb_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model whose read data
// appears one cycle after the address.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, io_full;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ifr;
    logic [31:0] pc;
    logic        mc_valid, if_rdy;
    logic [31:0] inst;
    logic        lr, lwr;
    logic [31:0] laddr, ldata;
    logic [1:0]  llen;
    logic        lsb_rdy;
    logic [31:0] lsb_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    mem_ctrl dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .rdy_in          (rdy),
        .clr_in          (clr),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr),
        .io_buffer_full  (io_full),
        .if_to_mc_ready  (ifr),
        .if_to_mc_PC     (pc),
        .mc_valid        (mc_valid),
        .mc_to_if_ready  (if_rdy),
        .mc_to_if_inst   (inst),
        .lsb_to_mc_ready (lr),
        .lsb_to_mc_wr    (lwr),
        .lsb_to_mc_addr  (laddr),
        .lsb_to_mc_len   (llen),
        .lsb_to_mc_data  (ldata),
        .mc_to_lsb_ready (lsb_rdy),
        .mc_to_lsb_data  (lsb_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
        ifr = 1'b0; pc = '0;
        lr = 1'b0; lwr = 1'b0; laddr = '0; llen = '0; ldata = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h93; ram[12'h101] = 8'h00; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        ram[12'h104] = 8'h13; ram[12'h105] = 8'h05; ram[12'h106] = 8'h00; ram[12'h107] = 8'h00;
        ram[12'h305] = 8'h80; ram[12'h306] = 8'h34; ram[12'h307] = 8'h12;
        for (int i = 12'h400; i < 12'h404; i++) ram[i] = 8'h55;

        tick(); tick();
        rst = 1'b0;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_lsb_data", lsb_data, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_valid", 32'(mc_valid), 32'h0);

        // Fetch 0x100
        ifr = 1'b1; pc = 32'h100;
        tick();
        chk("f1_valid", 32'(mc_valid), 32'h1);
        chk("f1_a0", mem_a, 32'h100);
        ifr = 1'b0;
        tick();
        chk("f1_valid_pulse", 32'(mc_valid), 32'h0);
        chk("f1_a1", mem_a, 32'h101);
        tick(); tick();
        chk("f1_a3", mem_a, 32'h103);
        tick();
        chk("f1_early", 32'(if_rdy), 32'h0);
        tick();
        chk("f1_rdy", 32'(if_rdy), 32'h1);
        chk("f1_inst", inst, 32'h00100093);
        tick();
        chk("f1_rdy_pulse", 32'(if_rdy), 32'h0);
        chk("f1_inst_hold", inst, 32'h00100093);

        // Word store and fetch requested together: LSB first
        lr = 1'b1; lwr = 1'b1; laddr = 32'h200; llen = 2'd2; ldata = 32'hDEADBEEF;
        ifr = 1'b1; pc = 32'h104;
        tick();
        chk("st_valid0", 32'(mc_valid), 32'h0);
        chk("st_wr0", 32'(mem_wr), 32'h1);
        chk("st_a0", mem_a, 32'h200);
        chk("st_d0", 32'(mem_dout), 32'hEF);
        ldata = 32'h0; laddr = 32'h999;
        tick();
        chk("st_a1", mem_a, 32'h201);
        chk("st_d1", 32'(mem_dout), 32'hBE);
        tick();
        chk("st_d2", 32'(mem_dout), 32'hAD);
        tick();
        chk("st_a3", mem_a, 32'h203);
        chk("st_d3", 32'(mem_dout), 32'hDE);
        chk("st_wr3", 32'(mem_wr), 32'h1);
        tick();
        chk("st_done", 32'(lsb_rdy), 32'h1);
        chk("st_wr_off", 32'(mem_wr), 32'h0);
        chk("st_valid4", 32'(mc_valid), 32'h0);
        lr = 1'b0; lwr = 1'b0;
        tick();
        chk("f2_valid", 32'(mc_valid), 32'h1);
        chk("f2_a0", mem_a, 32'h104);
        ifr = 1'b0;
        chk("st_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEADBEEF);
        tick(); tick(); tick(); tick();
        chk("f2_early", 32'(if_rdy), 32'h0);
        tick();
        chk("f2_rdy", 32'(if_rdy), 32'h1);
        chk("f2_inst", inst, 32'h00000513);

        // Byte load then half load
        lr = 1'b1; lwr = 1'b0; laddr = 32'h305; llen = 2'd0;
        tick();
        chk("lb_a", mem_a, 32'h305);
        chk("lb_wr", 32'(mem_wr), 32'h0);
        tick();
        chk("lb_early", 32'(lsb_rdy), 32'h0);
        tick();
        chk("lb_rdy", 32'(lsb_rdy), 32'h1);
        chk("lb_data", lsb_data, 32'h00000080);
        lr = 1'b0;
        tick();
        lr = 1'b1; laddr = 32'h306; llen = 2'd1;
        tick();
        chk("lh_a", mem_a, 32'h306);
        tick();
        chk("lh_early1", 32'(lsb_rdy), 32'h0);
        tick();
        chk("lh_early2", 32'(lsb_rdy), 32'h0);
        tick();
        chk("lh_rdy", 32'(lsb_rdy), 32'h1);
        chk("lh_data", lsb_data, 32'h00001234);
        lr = 1'b0;

        // Flush during the third byte of a fetch
        ifr = 1'b1; pc = 32'h100;
        tick();
        chk("fc_valid", 32'(mc_valid), 32'h1);
        ifr = 1'b0;
        tick(); tick();
        chk("fc_a2", mem_a, 32'h102);
        clr = 1'b1;
        tick();
        chk("fc_no_rdy", 32'(if_rdy), 32'h0);
        clr = 1'b0; ifr = 1'b1; pc = 32'h104;
        tick();
        chk("fc_refetch", 32'(mc_valid), 32'h1);
        chk("fc_a0", mem_a, 32'h104);
        ifr = 1'b0;
        tick();
        chk("fc_no_late", 32'(if_rdy), 32'h0);
        tick(); tick(); tick();
        chk("fc_early", 32'(if_rdy), 32'h0);
        tick();
        chk("fc_rdy", 32'(if_rdy), 32'h1);
        chk("fc_inst", inst, 32'h00000513);

        // IO store stalled by a full buffer, flush ignored mid-store
        lr = 1'b1; lwr = 1'b1; laddr = 32'h30000; llen = 2'd0; ldata = 32'h0000005A;
        io_full = 1'b1;
        tick();
        chk("io_stall0", 32'(mem_wr), 32'h0);
        tick();
        chk("io_stall1", 32'(mem_wr), 32'h0);
        tick();
        chk("io_stall2", 32'(mem_wr), 32'h0);
        io_full = 1'b0; clr = 1'b1;
        tick();
        chk("io_wr", 32'(mem_wr), 32'h1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_d", 32'(mem_dout), 32'h5A);
        tick();
        chk("io_done", 32'(lsb_rdy), 32'h1);
        chk("io_wr_off", 32'(mem_wr), 32'h0);
        lr = 1'b0; lwr = 1'b0;
        ifr = 1'b1; pc = 32'h400;
        tick();
        chk("idle_clr_block", 32'(mc_valid), 32'h0);
        clr = 1'b0;
        tick();
        chk("idle_accept", 32'(mc_valid), 32'h1);
        ifr = 1'b0;

        // Reset mid-read
        tick();
        rst = 1'b1;
        tick();
        chk("mr_mem_a", mem_a, 32'h0);
        chk("mr_dout", 32'(mem_dout), 32'h0);
        chk("mr_inst", inst, 32'h0);
        chk("mr_lsb_data", lsb_data, 32'h0);
        chk("mr_lsb_rdy", 32'(lsb_rdy), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_idle_rdy", 32'(if_rdy), 32'h0);
            chk("mr_idle_valid", 32'(mc_valid), 32'h0);
        end

        // Global stall for two cycles mid-read
        ifr = 1'b1; pc = 32'h400;
        tick();
        chk("rs_valid", 32'(mc_valid), 32'h1);
        ifr = 1'b0;
        tick();
        rdy = 1'b0;
        tick(); tick();
        chk("rs_hold_a", mem_a, 32'h401);
        rdy = 1'b1;
        tick(); tick();
        chk("rs_not_yet5", 32'(if_rdy), 32'h0);
        tick();
        chk("rs_not_yet6", 32'(if_rdy), 32'h0);
        tick();
        chk("rs_rdy", 32'(if_rdy), 32'h1);
        chk("rs_inst", inst, 32'h55555555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
